bus_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer directly upstream of the Mux10 bus multiplexer.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/bus_ctrl_fsm_dec.sv | 17 +
 rtl/bus_ctrl_fsm.sv | 135 +++++++++++++
 tb/tb_bus_ctrl_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the Mux10 bus control sequencer.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
//
// Holds the opcode values, the sequencer state encoding, the one-hot Mux10
// select constants and the instruction field positions.
package cpu_pkg;

  // Opcodes (instr[15:12]); 4..15 are undefined
  localparam logic [3:0] OP_MV  = 4'd0;
  localparam logic [3:0] OP_MVI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;

  // Instruction field positions
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RX_MSB = 11;
  localparam int RX_LSB = 9;
  localparam int RY_MSB = 8;
  localparam int RY_LSB = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  // Mux10 select bits: R1..R7 sit on bits 0..6, R0 is on bit 8
  localparam logic [9:0] SEL_R1  = 10'h001;
  localparam logic [9:0] SEL_R2  = 10'h002;
  localparam logic [9:0] SEL_R3  = 10'h004;
  localparam logic [9:0] SEL_R4  = 10'h008;
  localparam logic [9:0] SEL_R5  = 10'h010;
  localparam logic [9:0] SEL_R6  = 10'h020;
  localparam logic [9:0] SEL_R7  = 10'h040;
  localparam logic [9:0] SEL_G   = 10'h080;
  localparam logic [9:0] SEL_R0  = 10'h100;
  localparam logic [9:0] SEL_IMM = 10'h200;

  // Remap a one-hot register vector (bit k = Rk) onto the Mux10 select layout
  function automatic logic [9:0] reg_to_sel(input logic [7:0] reg_oh);
    logic [9:0] sel;
    sel = '0;
    if (reg_oh[0]) sel = sel | SEL_R0;
    if (reg_oh[1]) sel = sel | SEL_R1;
    if (reg_oh[2]) sel = sel | SEL_R2;
    if (reg_oh[3]) sel = sel | SEL_R3;
    if (reg_oh[4]) sel = sel | SEL_R4;
    if (reg_oh[5]) sel = sel | SEL_R5;
    if (reg_oh[6]) sel = sel | SEL_R6;
    if (reg_oh[7]) sel = sel | SEL_R7;
    return sel;
  endfunction

endpackage

// File: rtl/bus_ctrl_fsm_dec.sv
// 3-bit index to 8-bit one-hot decoder with enable.
// Latency: combinational.
// Backpressure: none.
//
// Ports: idx (register index), en (decode enable), oh (one-hot result, zero when en=0).
module dec3to8_onehot (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] oh
);

  always_comb begin
    oh = '0;
    if (en) oh[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_ctrl_fsm.sv
// Multi-cycle MV/MVI/ADD/SUB sequencer driving Mux10 select and register/A/G loads.
// Latency: done 1 cycle after accept for MV/MVI/illegal, 3 cycles for ADD/SUB.
// Backpressure: instr_ready only in IDLE; one instruction per (steps+1) cycles.
//
// Ports: clk, rst_n (sync active-low); instr/instr_valid/instr_ready handshake;
// bus_sel (Mux10 one-hot), r_in, a_in, g_in, alu_sub load/ALU controls;
// done/illegal completion pulses; retired_cnt wrapping count of done pulses.
//
// All outputs are registered: the next state and next latched instruction are
// decoded combinationally and the result is captured on the same edge that
// moves the state, so each output is a pure function of (state, latched instr).
module bus_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int NUM_REG = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [9:0]         bus_sel,
  output logic [NUM_REG-1:0] r_in,
  output logic               a_in,
  output logic               g_in,
  output logic               alu_sub,
  output logic               done,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired_cnt
);

  state_t             state, nxt_state;
  logic [INSTR_W-1:0] ir, nxt_ir;

  logic [3:0] nxt_op;
  logic [2:0] nxt_rx, nxt_ry;
  logic       nxt_is_mv, nxt_is_mvi, nxt_is_alu;

  logic       wr_en, bus_reg_en;
  logic [2:0] bus_reg_idx;
  logic [7:0] wr_oh, bus_reg_oh;

  logic [9:0]         nxt_bus_sel;
  logic               nxt_a_in, nxt_g_in, nxt_alu_sub, nxt_done, nxt_illegal;

  // Low instruction bits carry no meaning for this sequencer
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[RY_LSB-1:0];

  always_comb begin
    nxt_state = state;
    nxt_ir    = ir;
    unique case (state)
      S_IDLE: if (instr_valid) begin
        nxt_ir    = instr;
        nxt_state = S_T1;
      end
      S_T1: nxt_state = (ir[OP_MSB:OP_LSB] == OP_ADD || ir[OP_MSB:OP_LSB] == OP_SUB)
                        ? S_T2 : S_IDLE;
      S_T2: nxt_state = S_T3;
      S_T3: nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  assign nxt_op     = nxt_ir[OP_MSB:OP_LSB];
  assign nxt_rx     = nxt_ir[RX_MSB:RX_LSB];
  assign nxt_ry     = nxt_ir[RY_MSB:RY_LSB];
  assign nxt_is_mv  = (nxt_op == OP_MV);
  assign nxt_is_mvi = (nxt_op == OP_MVI);
  assign nxt_is_alu = (nxt_op == OP_ADD) || (nxt_op == OP_SUB);

  // rx is written in the single step of MV/MVI and in the last step of ADD/SUB
  assign wr_en = ((nxt_state == S_T1) && (nxt_is_mv || nxt_is_mvi)) || (nxt_state == S_T3);

  // A register drives the bus: ry for MV, rx then ry for ADD/SUB
  assign bus_reg_en  = ((nxt_state == S_T1) && (nxt_is_mv || nxt_is_alu)) || (nxt_state == S_T2);
  assign bus_reg_idx = ((nxt_state == S_T1) && nxt_is_alu) ? nxt_rx : nxt_ry;

  dec3to8_onehot u_dec_wr (
    .idx (nxt_rx),
    .en  (wr_en),
    .oh  (wr_oh)
  );

  dec3to8_onehot u_dec_bus (
    .idx (bus_reg_idx),
    .en  (bus_reg_en),
    .oh  (bus_reg_oh)
  );

  always_comb begin
    nxt_bus_sel = reg_to_sel(bus_reg_oh);
    if ((nxt_state == S_T1) && nxt_is_mvi) nxt_bus_sel = nxt_bus_sel | SEL_IMM;
    if (nxt_state == S_T3)                 nxt_bus_sel = nxt_bus_sel | SEL_G;
  end

  assign nxt_a_in    = (nxt_state == S_T1) && nxt_is_alu;
  assign nxt_g_in    = (nxt_state == S_T2);
  assign nxt_alu_sub = (nxt_state == S_T2) && nxt_op[0];
  assign nxt_done    = ((nxt_state == S_T1) && !nxt_is_alu) || (nxt_state == S_T3);
  assign nxt_illegal = (nxt_state == S_T1) && !(nxt_is_mv || nxt_is_mvi || nxt_is_alu);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ir          <= '0;
      instr_ready <= 1'b1;
      bus_sel     <= '0;
      r_in        <= '0;
      a_in        <= 1'b0;
      g_in        <= 1'b0;
      alu_sub     <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state       <= nxt_state;
      ir          <= nxt_ir;
      instr_ready <= (nxt_state == S_IDLE);
      bus_sel     <= nxt_bus_sel;
      r_in        <= wr_oh;
      a_in        <= nxt_a_in;
      g_in        <= nxt_g_in;
      alu_sub     <= nxt_alu_sub;
      done        <= nxt_done;
      illegal     <= nxt_illegal;
      // done is the registered pulse of the cycle now ending
      if (done) retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_bus_ctrl_fsm.sv
module tb_bus_ctrl_fsm;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [9:0]       bus_sel;
  logic [7:0]       r_in;
  logic             a_in, g_in, alu_sub, done, illegal;
  logic [CNT_W-1:0] retired_cnt;

  bus_ctrl_fsm #(.INSTR_W(16), .NUM_REG(8), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .bus_sel     (bus_sel),
    .r_in        (r_in),
    .a_in        (a_in),
    .g_in        (g_in),
    .alu_sub     (alu_sub),
    .done        (done),
    .illegal     (illegal),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  // Expected output vector of one bus cycle
  typedef struct {
    logic [9:0] sel;
    logic [7:0] rin;
    logic       a, g, sub, dn, ill;
  } step_t;

  step_t q[$];
  int    cnt_model;
  int    checks = 0;
  int    errors = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Mux10 input for a register: R0 on input 8, Rk on input k-1
  function automatic logic [9:0] sel_of(input int r);
    logic [9:0] s;
    s = (r == 0) ? 10'h100 : (10'h001 << (r - 1));
    return s;
  endfunction

  function automatic step_t mk(input logic [9:0] sel, input logic [7:0] rin,
                               input logic a, input logic g, input logic sub,
                               input logic dn, input logic ill);
    step_t s;
    s.sel = sel; s.rin = rin; s.a = a; s.g = g; s.sub = sub; s.dn = dn; s.ill = ill;
    return s;
  endfunction

  // Cycle-by-cycle behaviour of one instruction, straight from the opcode table
  task automatic push_steps(input logic [15:0] ins);
    int op, rx, ry;
    logic [7:0] wx;
    op = int'(ins[15:12]);
    rx = int'(ins[11:9]);
    ry = int'(ins[8:6]);
    wx = 8'h01 << rx;
    case (op)
      0: q.push_back(mk(sel_of(ry), wx, 0, 0, 0, 1, 0));
      1: q.push_back(mk(10'h200,    wx, 0, 0, 0, 1, 0));
      2, 3: begin
        q.push_back(mk(sel_of(rx), 8'h00, 1, 0, 0, 0, 0));
        q.push_back(mk(sel_of(ry), 8'h00, 0, 1, (op == 3), 0, 0));
        q.push_back(mk(10'h080,    wx,    0, 0, 0, 1, 0));
      end
      default: q.push_back(mk(10'h000, 8'h00, 0, 0, 0, 1, 1));
    endcase
  endtask

  task automatic check_outputs();
    step_t e;
    e = (q.size() != 0) ? q[0] : mk(10'h000, 8'h00, 0, 0, 0, 0, 0);
    chk_val("ready",   32'(instr_ready), 32'(q.size() == 0));
    chk_val("bus_sel", 32'(bus_sel), 32'(e.sel));
    chk_val("r_in",    32'(r_in),    32'(e.rin));
    chk_val("a_in",    32'(a_in),    32'(e.a));
    chk_val("g_in",    32'(g_in),    32'(e.g));
    chk_val("alu_sub", 32'(alu_sub), 32'(e.sub));
    chk_val("done",    32'(done),    32'(e.dn));
    chk_val("illegal", 32'(illegal), 32'(e.ill));
    chk_val("retired", 32'(retired_cnt), 32'(cnt_model % (1 << CNT_W)));
    chk_val("oh0_bus", 32'($onehot0(bus_sel)), 32'd1);
    chk_val("oh0_rin", 32'($onehot0(r_in)), 32'd1);
  endtask

  // Drive inputs for the coming edge, advance the model across it, check after it
  task automatic step(input logic v, input logic [15:0] ins, input logic r);
    instr_valid = v;
    instr       = ins;
    rst_n       = r;
    if (!r) begin
      q.delete();
      cnt_model = 0;
    end else if (q.size() == 0) begin
      if (v) push_steps(ins);
    end else begin
      if (q[0].dn) cnt_model++;
      void'(q.pop_front());
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; cnt_model = 0;
    @(negedge clk);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);

    // Reset held for two edges while an ADD sits in T2
    step(1, 16'h2280, 1);
    step(0, 16'h0000, 1);
    chk_val("rst_in_t2_g", 32'(g_in), 32'd1);
    step(0, 16'h0000, 0);
    step(0, 16'h0000, 0);
    chk_val("rst_bus", 32'(bus_sel), 32'd0);
    chk_val("rst_cnt", 32'(retired_cnt), 32'd0);
    step(0, 16'h0000, 1);
    chk_val("rst_nodone", 32'(done), 32'd0);

    // MV R5 <- R0
    step(1, 16'h0A00, 1);
    chk_val("mv_bus", 32'(bus_sel), 32'h100);
    chk_val("mv_rin", 32'(r_in), 32'h20);
    step(0, 16'h0000, 1);
    chk_val("mv_ready", 32'(instr_ready), 32'd1);

    // ADD R1,R2
    step(1, 16'h2280, 1);
    chk_val("add_t1", 32'(bus_sel), 32'h001);
    step(0, 16'h0000, 1);
    chk_val("add_t2", 32'(bus_sel), 32'h002);
    step(0, 16'h0000, 1);
    chk_val("add_t3", 32'(bus_sel), 32'h080);
    chk_val("add_t3_rin", 32'(r_in), 32'h02);
    step(0, 16'h0000, 1);

    // SUB R7,R7 then MVI R0 with valid held high
    step(1, 16'h3FC0, 1);
    step(1, 16'h1000, 1);
    chk_val("sub_alu", 32'(alu_sub), 32'd1);
    step(1, 16'h1000, 1);
    step(1, 16'h1000, 1);
    chk_val("sub_idle_ready", 32'(instr_ready), 32'd1);
    step(1, 16'h1000, 1);
    chk_val("mvi_bus", 32'(bus_sel), 32'h200);
    chk_val("mvi_rin", 32'(r_in), 32'h01);
    step(0, 16'h0000, 1);

    // Illegal opcode
    step(1, 16'hF000, 1);
    chk_val("ill_pulse", 32'({done, illegal}), 32'h3);
    step(0, 16'h0000, 1);

    // Counter wrap: reset, retire 15 then one more
    step(0, 16'h0000, 0);
    for (int i = 0; i < 15; i++) begin
      step(1, 16'h0A40, 1);
      step(0, 16'h0000, 1);
    end
    chk_val("wrap_15", 32'(retired_cnt), 32'd15);
    step(1, 16'h0A40, 1);
    step(0, 16'h0000, 1);
    chk_val("wrap_0", 32'(retired_cnt), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ins;
      logic v, r;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ins[15:12] = 4'($urandom_range(0, 3));
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 99) != 0);
      step(v, ins, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
